// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared loader states, stream constants and state decode helper
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_HI,
    ST_LO,
    ST_CHK,
    ST_REL,
    ST_ERR
  } state_t;

  // Data words arrive high byte first on the stream.
  localparam bit HIGH_BYTE_FIRST = 1'b1;

  // A count byte of zero stands for a full 256-word image.
  localparam logic [8:0] COUNT_ZERO_WORDS = 9'd256;

  // States in which the loader takes bytes from the stream.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_ADDR) || (s == ST_COUNT) || (s == ST_HI) ||
           (s == ST_LO) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream, instruction-RAM write and CPU control bundle
interface program_loader_if;
  logic        load_req;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  // Host side: requests loads and supplies the byte stream.
  modport master (
    output load_req, in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
  );

  // Loader side.
  modport slave (
    input  load_req, in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, error
  );
endinterface

// File: rtl/loader_checksum.sv
// rtl/loader_checksum.sv - 8-bit XOR accumulator with clear and enable
module loader_checksum (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic [7:0] i_data,
  output logic [7:0] o_sum
);
  logic [7:0] r_sum;

  // Fold each enabled byte into the running XOR; clear wins over enable.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_sum <= 8'h00;
    end else if (i_clear) begin
      r_sum <= 8'h00;
    end else if (i_enable) begin
      r_sum <= r_sum ^ i_data;
    end
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction-RAM loader; checksum stage under PROGRAM_LOADER_CHECKSUM_EN
module program_loader
  import loader_pkg::*;
#(
  parameter bit BOOT_LOAD = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  program_loader_if.slave  bus
);
  state_t      r_state;
  state_t      w_next;
  logic        r_in_ready;
  logic        r_cpu_hold;
  logic        r_busy;
  logic        r_done;
  logic        r_imem_we;
  logic [7:0]  r_addr;
  logic [7:0]  r_imem_addr;
  logic [7:0]  r_first_byte;
  logic [15:0] r_imem_wdata;
  logic [8:0]  r_count;
  logic        w_accept;
  logic        w_start;
  logic        w_last;
  logic [15:0] w_word;

  assign w_accept = bus.in_valid & r_in_ready;
  assign w_start  = bus.load_req & ((r_state == ST_IDLE) || (r_state == ST_ERR));
  assign w_last   = (r_count == 9'd1);
  assign w_word   = HIGH_BYTE_FIRST ? {r_first_byte, bus.in_data} : {bus.in_data, r_first_byte};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] w_sum;
  logic       w_sum_ok;
  logic       r_error;

  loader_checksum u_checksum (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (w_start),
    .i_enable (w_accept),
    .i_data   (bus.in_data),
    .o_sum    (w_sum)
  );

  assign w_sum_ok  = (bus.in_data == w_sum);
  assign bus.error = r_error;

  // Error is simply "sitting in ERR", so a new request clears it.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) r_error <= 1'b0;
    else          r_error <= (w_next == ST_ERR);
  end
`else
  assign bus.error = 1'b0;
`endif

  // Next-state selection for the load sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERR: if (w_start) w_next = ST_ADDR;
      ST_ADDR:  if (w_accept) w_next = ST_COUNT;
      ST_COUNT: if (w_accept) w_next = ST_HI;
      ST_HI:    if (w_accept) w_next = ST_LO;
      ST_LO: begin
        if (w_accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          w_next = w_last ? ST_CHK : ST_HI;
`else
          w_next = w_last ? ST_REL : ST_HI;
`endif
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ST_CHK:   if (w_accept) w_next = w_sum_ok ? ST_REL : ST_ERR;
`endif
      ST_REL:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs. done/cpu-release are taken from
  // the REL state register so they appear one cycle after the final write
  // pulse, i.e. only once the RAM has committed the last word.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= BOOT_LOAD ? ST_ADDR : ST_IDLE;
      r_in_ready   <= BOOT_LOAD;
      r_cpu_hold   <= BOOT_LOAD;
      r_busy       <= BOOT_LOAD;
      r_done       <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= 8'h00;
      r_imem_wdata <= 16'h0000;
      r_addr       <= 8'h00;
      r_first_byte <= 8'h00;
      r_count      <= 9'd0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= accepts_bytes(w_next);
      r_cpu_hold <= (w_next != ST_IDLE);
      r_busy     <= !((w_next == ST_IDLE) || (w_next == ST_ERR));
      r_done     <= (r_state == ST_REL);
      r_imem_we  <= 1'b0;
      if (w_accept) begin
        case (r_state)
          ST_ADDR:  r_addr <= bus.in_data;
          ST_COUNT: r_count <= (bus.in_data == 8'h00) ? COUNT_ZERO_WORDS : {1'b0, bus.in_data};
          ST_HI:    r_first_byte <= bus.in_data;
          ST_LO: begin
            r_imem_we    <= 1'b1;
            r_imem_addr  <= r_addr;
            r_imem_wdata <= w_word;
            r_addr       <= r_addr + 8'd1;
            r_count      <= r_count - 9'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader against a stream-level model
module tb_program_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  program_loader_if bus();

  program_loader dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [15:0] ram [256];
  logic [23:0] obs_q [$];
  logic [23:0] exp_q [$];
  logic [15:0] words [$];

  // The instruction RAM as the CPU would see it, plus a log of every write.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      obs_q.push_back({bus.imem_addr, bus.imem_wdata});
      ram[bus.imem_addr] = bus.imem_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string pfx);
    check_eq({pfx, "_rdy"},   bus.in_ready,   1);
    check_eq({pfx, "_hold"},  bus.cpu_hold,   1);
    check_eq({pfx, "_busy"},  bus.busy,       1);
    check_eq({pfx, "_done"},  bus.done,       0);
    check_eq({pfx, "_err"},   bus.error,      0);
    check_eq({pfx, "_we"},    bus.imem_we,    0);
    check_eq({pfx, "_addr"},  bus.imem_addr,  0);
    check_eq({pfx, "_wdata"}, bus.imem_wdata, 0);
  endtask

  task automatic fill_random(input int nw);
    words.delete();
    for (int i = 0; i < nw; i++) words.push_back(16'($urandom));
  endtask

  // Called at a negedge; returns at the negedge right after the byte is taken.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    if (stall && ($urandom_range(0, 1) == 1)) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n = 0;
    while ((bus.in_ready !== 1'b1) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 0, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic request(input bit with_byte, input logic [7:0] b);
    bus.load_req = 1'b1;
    if (with_byte) begin
      bus.in_valid = 1'b1;
      bus.in_data  = b;
    end
    check_eq("idle_rdy", bus.in_ready, 0);
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("req_busy", bus.busy, 1);
    check_eq("req_hold", bus.cpu_hold, 1);
    check_eq("req_err",  bus.error, 0);
    check_eq("req_rdy",  bus.in_ready, 1);
  endtask

  // Streams one image taken from 'words' and checks writes and release.
  task automatic run_load(input logic [7:0] a, input logic [7:0] n, input bit stall,
                          input bit poke_hi, input bit bad_csum);
    int nw;
    logic [7:0] x, hi, lo;
    nw = (n == 8'h00) ? 256 : int'(n);
    exp_q.delete();
    obs_q.delete();
    for (int i = 0; i < nw; i++) exp_q.push_back({8'(int'(a) + i), words[i]});
    x = a ^ n;
    send_byte(a, stall);
    send_byte(n, stall);
    for (int i = 0; i < nw; i++) begin
      hi = words[i][15:8];
      lo = words[i][7:0];
      if (poke_hi && i == 0) bus.load_req = 1'b1;
      send_byte(hi, stall);
      bus.load_req = 1'b0;
      send_byte(lo, stall);
      x = x ^ hi ^ lo;
    end
    if (CSUM_EN) send_byte(bad_csum ? (x ^ 8'h01) : x, stall);
    if (CSUM_EN && bad_csum) begin
      check_eq("bad_err",  bus.error, 1);
      check_eq("bad_hold", bus.cpu_hold, 1);
      check_eq("bad_busy", bus.busy, 0);
      check_eq("bad_done", bus.done, 0);
      @(negedge clk);
      check_eq("bad_err2", bus.error, 1);
    end else begin
      check_eq("last_we",   bus.imem_we, CSUM_EN ? 0 : 1);
      check_eq("pre_done",  bus.done, 0);
      check_eq("pre_hold",  bus.cpu_hold, 1);
      @(negedge clk);
      check_eq("done",      bus.done, 1);
      check_eq("rel_hold",  bus.cpu_hold, 0);
      check_eq("rel_busy",  bus.busy, 0);
      @(negedge clk);
      check_eq("done_off",  bus.done, 0);
      check_eq("idle_hold", bus.cpu_hold, 0);
      check_eq("idle_rdy2", bus.in_ready, 0);
    end
    check_eq("n_writes", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) check_eq($sformatf("wr%0d", i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] a;
    logic [15:0] w0;
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("boot");

    // Boot-time load straight out of reset.
    words = '{16'h0AE5, 16'h0BB8};
    run_load(8'h0A, 8'h02, 1'b0, 1'b0, 1'b0);

    // Full 256-word image wrapping through address 0.
    request(1'b0, 8'h00);
    fill_random(256);
    run_load(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

    // Stalled stream with an ignored request during HI.
    request(1'b0, 8'h00);
    fill_random(5);
    run_load(8'($urandom), 8'd5, 1'b1, 1'b1, 1'b0);

    // Request and valid together in IDLE: the byte must be re-presented.
    a = 8'($urandom);
    request(1'b1, a);
    fill_random(2);
    run_load(a, 8'd2, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      int cnt;
      cnt = $urandom_range(1, 12);
      request(1'b0, 8'h00);
      fill_random(cnt);
      run_load(8'($urandom), 8'(cnt), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    // Reset part-way through a 3-word load.
    obs_q.delete();
    a  = 8'($urandom);
    w0 = 16'($urandom);
    request(1'b0, 8'h00);
    send_byte(a, 1'b0);
    send_byte(8'd3, 1'b0);
    send_byte(w0[15:8], 1'b0);
    send_byte(w0[7:0], 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    #2 rst_n = 1'b0;
    #1 check_reset_outs("midrst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("midrst_nwr", obs_q.size(), 1);
    check_eq("midrst_ram", ram[a], w0);
    @(negedge clk);
    check_reset_outs("reboot");

    // Boot-time load again after the aborted one.
    fill_random(2);
    run_load(8'($urandom), 8'd2, 1'b0, 1'b0, 1'b0);

    if (CSUM_EN) begin
      request(1'b0, 8'h00);
      words = '{16'h9800};
      run_load(8'h10, 8'h01, 1'b0, 1'b0, 1'b0);
      request(1'b0, 8'h00);
      words = '{16'h9800};
      run_load(8'h10, 8'h01, 1'b0, 1'b0, 1'b1);
      request(1'b0, 8'h00);
      fill_random(4);
      run_load(8'($urandom), 8'd4, 1'b1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Writable-instruction-memory loader for the 8-bit single-cycle CPU. It is the writer side of the instruction memory interface that the CPU fetch path reads. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them to consecutive instruction-RAM addresses. While loading, it holds the CPU in reset and releases the CPU once the image is committed.

## Interface
Parameters:
- BOOT_LOAD, 1: state after reset. 1 = enter ADDR with cpu_hold high (boot-time load). 0 = enter IDLE with CPU running.

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- load_req  in  1  one-cycle request to start a load; honoured only in IDLE or ERR
- in_valid  in  1  byte-stream valid
- in_data  in  8  byte-stream data
- in_ready  out  1  byte-stream ready; byte accepted when in_valid & in_ready at posedge
- imem_we  out  1  instruction-RAM write enable, one-cycle pulse per word
- imem_addr  out  8  instruction-RAM write address
- imem_wdata  out  16  instruction word, {high byte, low byte}
- cpu_hold  out  1  high holds the CPU and PC in reset
- busy  out  1  high in any state other than IDLE, ERR
- done  out  1  one-cycle pulse on successful load completion
- error  out  1  sticky checksum-mismatch flag

## Operation
- Stream format: start address byte, count byte N (0 encodes 256 words), then 2N data bytes per word, high byte first. An optional checksum byte follows (see Configuration).
- States:
  - IDLE: in_ready=0, cpu_hold=0. Goes to ADDR on load_req.
  - ADDR: accept byte into addr register, go to COUNT.
  - COUNT: accept byte into remaining-word counter, go to HI.
  - HI: accept byte into wdata[15:8], go to LO.
  - LO: accept byte into wdata[7:0] and issue the write. If the last word, go to CHK (if configured) or REL. Otherwise go to HI.
  - CHK: accept checksum byte. Go to REL on match, ERR on mismatch.
  - REL: one cycle. done=1, cpu_hold drops, then go to IDLE.
  - ERR: in_ready=0, cpu_hold=1, error=1. Goes to ADDR on load_req, which clears error.
- in_ready is high in ADDR, COUNT, HI, LO, CHK.
- Address increments by 1 after each write and wraps 8'hFF→8'h00 silently.
- Word counter is 9 bits. Count 0 loads 256. The last word is detected when the counter equals 1 at LO accept.
- load_req while busy is ignored; no restart.
- load_req and in_valid in the same cycle in IDLE: the request is taken, the byte is not accepted (in_ready=0).
- Reset values: in_ready=BOOT_LOAD, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=BOOT_LOAD, busy=BOOT_LOAD, done=0, error=0. State is ADDR if BOOT_LOAD, else IDLE.
- Reset asserted mid-load aborts immediately. Words already written stay in RAM; no rollback.

## Timing
- Back-to-back acceptance: one byte per cycle sustained; no bubbles between words.
- Write latency: for a LO byte accepted at edge k, imem_we/imem_addr/imem_wdata are registered and valid for the cycle following k. The RAM commits at edge k+1.
- Release: REL is entered no earlier than edge k+1 after the final accepted byte (LO, or CHK if configured). done is high for exactly one cycle and cpu_hold is low from that same cycle. The CPU therefore never samples deasserted reset before the last write is committed.
- in_ready, cpu_hold, busy and done are registered outputs (state-decoded from registers); there is no combinational path from input to output.

## Configuration
- PROGRAM_LOADER_CHECKSUM_EN defined:
  - CHK state exists. The checksum byte must equal the XOR of all accepted bytes of the current load (addr, count, data).
  - The accumulator clears on entry to ADDR.
  - Mismatch goes to ERR; cpu_hold stays high.
- Undefined:
  - No CHK state; LO(last) goes directly to REL.
  - error is tied 0 and ERR is unreachable.

## Structure
- Shared package loader_pkg: state enum (IDLE, ADDR, COUNT, HI, LO, CHK, REL, ERR), stream byte-order constant (high byte first), count-zero-means-256 constant.
- One natural sub-module: loader_checksum, an 8-bit XOR accumulator with clear/enable. It is instantiated only under PROGRAM_LOADER_CHECKSUM_EN.
- The FSM, counters and write register stay in program_loader.

## Test plan
- Boot load with BOOT_LOAD=1 after reset. Stream 8'h0A, 8'h02, 8'h0A, 8'hE5, 8'h0B, 8'hB8 back-to-back → two writes: (8'h0A, 16'h0AE5) then (8'h0B, 16'h0BB8). cpu_hold falls with a one-cycle done pulse after the second write.
- Wrap and 256-word load. load_req from IDLE, then addr 8'hFF, count 8'h00, 512 bytes → 256 writes, with addresses FF, 00, 01, … FE.
- Handshake stall. in_valid toggles 1/0 every cycle mid-word → no byte is lost or duplicated, and imem_we pulses only after each LO byte.
- Ignored and simultaneous requests. load_req pulsed during HI → no effect on the load. load_req plus in_valid in IDLE → the request is taken and the first byte is re-presented as the address.
- Reset mid-load. Drop reset after the first word is written of count 3 → all outputs return to their reset values; word 0 remains in RAM.
- Checksum (macro on):
  - Stream 8'h10, 8'h01, 8'h98, 8'h00 with checksum 8'h89 → done.
  - Same stream with checksum 8'h88 → error=1, cpu_hold stays 1.
  - A following load_req clears error.
